// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   REDIR_REL / REDIR_ABS : encodings of redirect_mode
//   pc_step()             : bytes the PC advances per instruction
//   sext_imm()            : sign-extends a narrow redirect offset to SEXT_W bits
package fetch_pkg;

  localparam logic REDIR_REL = 1'b0;
  localparam logic REDIR_ABS = 1'b1;

  // Widest PC the sign-extension helper supports.
  localparam int unsigned SEXT_W = 64;

  function automatic int unsigned pc_step(input int unsigned instr_w);
    return instr_w / 8;
  endfunction

  // Shift the sign bit of an imm_w-wide value to the MSB, then shift it back arithmetically.
  function automatic logic [SEXT_W-1:0] sext_imm(input logic [SEXT_W-1:0] imm,
                                                input int unsigned       imm_w);
    logic [SEXT_W-1:0] shl;
    shl = imm << (SEXT_W - imm_w);
    return SEXT_W'($signed(shl) >>> (SEXT_W - imm_w));
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding {instr, pc} pairs between the BRAM and decode.
// Ports:
//   clock, reset : clock and asynchronous active-high reset
//   push, din    : enqueue din (caller guarantees no overflow)
//   pop          : dequeue head (caller guarantees non-empty)
//   flush        : empty the queue; overrides push and pop
//   head         : entry at the front of the queue (zero after reset)
//   count        : number of valid entries, 0..2
module fetch_queue #(
  parameter int unsigned W = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;

  // Next-state: entry 0 is always the head, entry 1 shifts down on pop.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = din;
          else               e1_d = din;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_d = e1_q;
            e1_d = din;
          end else begin
            e0_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = e0_q;
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, drives a 1-cycle-latency instruction BRAM,
// buffers responses in a 2-entry queue and hands them to decode via valid/ready.
// Ports:
//   clock, reset          : clock and asynchronous active-high reset
//   redirect_*            : redirect request; relative (base + sext(imm)) or absolute target
//   imem_en, imem_addr    : BRAM read strobe and address
//   imem_rdata            : BRAM data for the address strobed in the previous cycle
//   out_valid/ready/instr/pc : decode-side handshake and payload
//   fetch_cnt, cycle_cnt  : wrapping counts of accepted instructions and cycles
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter int unsigned     IMM_W    = 12,
  parameter int unsigned     CNT_W    = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic               redirect_mode,
  input  logic [PC_W-1:0]    redirect_base,
  input  logic [IMM_W-1:0]   redirect_imm,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   cycle_cnt
);

  localparam int unsigned     ENT_W = INSTR_W + PC_W;
  localparam logic [PC_W-1:0] STEP  = PC_W'(pc_step(INSTR_W));

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

  logic [1:0]       q_count;
  logic [ENT_W-1:0] q_head;
  logic             pop_c;
  logic             push_c;
  logic             issue_c;
  logic [2:0]       occ_c;
  logic [PC_W-1:0]  rel_tgt_c;
  logic [PC_W-1:0]  raw_tgt_c;
  logic [PC_W-1:0]  tgt_c;

  fetch_queue #(
    .W (ENT_W)
  ) u_queue (
    .clock (clock),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .flush (redirect_valid),
    .din   ({imem_rdata, inflight_pc_q}),
    .head  (q_head),
    .count (q_count)
  );

  // Redirect target, word-aligned.
  assign rel_tgt_c = redirect_base + PC_W'(sext_imm(SEXT_W'(redirect_imm), IMM_W));
  assign raw_tgt_c = (redirect_mode == REDIR_ABS) ? redirect_target : rel_tgt_c;
  assign tgt_c     = {raw_tgt_c[PC_W-1:2], 2'b00};

  assign pop_c  = out_valid && out_ready;
  // A redirect kills the response arriving this cycle.
  assign push_c = inflight_q && !redirect_valid;

  // Issue only while queue + in-flight, after this cycle's pop, leaves room for one more.
  // Gated by reset so the strobe is quiet while reset is held.
  assign occ_c   = 3'(q_count) + 3'(inflight_q);
  assign issue_c = !reset && !redirect_valid && (occ_c <= (3'(pop_c) + 3'd1));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue_c;
    inflight_pc_d = inflight_pc_q;
    fetch_cnt_d   = fetch_cnt_q + CNT_W'(pop_c);
    cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
    if (redirect_valid) begin
      fetch_pc_d = tgt_c;
    end else if (issue_c) begin
      fetch_pc_d    = fetch_pc_q + STEP;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      fetch_cnt_q   <= '0;
      cycle_cnt_q   <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fetch_cnt_q   <= fetch_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign imem_en   = issue_c;
  assign imem_addr = fetch_pc_q;
  assign out_valid = (q_count != 2'd0);
  assign out_instr = q_head[ENT_W-1:PC_W];
  assign out_pc    = q_head[PC_W-1:0];
  assign fetch_cnt = fetch_cnt_q;
  assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: streaming, stall, redirects,
// asynchronous mid-stream reset and PC wrap on a narrow-PC instance.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        redirect_valid;
  logic        redirect_mode;
  logic [31:0] redirect_base;
  logic [11:0] redirect_imm;
  logic [31:0] redirect_target;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [9:0]  fetch_cnt;
  logic [9:0]  cycle_cnt;

  logic        rst_w;
  logic        imem_en_w;
  logic [7:0]  imem_addr_w;
  logic [31:0] imem_rdata_w;
  logic        out_valid_w;
  logic        out_ready_w;
  logic [31:0] out_instr_w;
  logic [7:0]  out_pc_w;
  logic [9:0]  fetch_cnt_w;
  logic [9:0]  cycle_cnt_w;

  int n_checks;
  int n_bad;

  logic [31:0] stall_pc [13];
  logic        stall_en [13];
  logic [7:0]  wrap_pc  [4];

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_mode   (redirect_mode),
    .redirect_base   (redirect_base),
    .redirect_imm    (redirect_imm),
    .redirect_target (redirect_target),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .fetch_cnt       (fetch_cnt),
    .cycle_cnt       (cycle_cnt)
  );

  fetch_unit #(
    .PC_W     (8),
    .RESET_PC (8'hF8)
  ) dut_w (
    .clock           (clock),
    .reset           (rst_w),
    .redirect_valid  (1'b0),
    .redirect_mode   (1'b0),
    .redirect_base   (8'h00),
    .redirect_imm    (12'h000),
    .redirect_target (8'h00),
    .imem_en         (imem_en_w),
    .imem_addr       (imem_addr_w),
    .imem_rdata      (imem_rdata_w),
    .out_valid       (out_valid_w),
    .out_ready       (out_ready_w),
    .out_instr       (out_instr_w),
    .out_pc          (out_pc_w),
    .fetch_cnt       (fetch_cnt_w),
    .cycle_cnt       (cycle_cnt_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memories: word k holds k; the narrow instance holds 0x1000 + addr.
  always @(posedge clock) begin
    if (imem_en)   imem_rdata   <= imem_addr >> 2;
    if (imem_en_w) imem_rdata_w <= 32'h1000 + 32'(imem_addr_w);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks        = 0;
    n_bad           = 0;
    reset           = 1'b1;
    rst_w           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_mode   = 1'b0;
    redirect_base   = '0;
    redirect_imm    = '0;
    redirect_target = '0;
    out_ready       = 1'b0;
    out_ready_w     = 1'b0;
    imem_rdata      = '0;
    imem_rdata_w    = '0;
    stall_pc = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4,
                 32'h8, 32'hC, 32'h10};
    stall_en = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    wrap_pc  = '{8'hF8, 8'hFC, 8'h00, 8'h04};

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_instr", out_instr, 0);
    check_eq("rst_pc", out_pc, 0);
    check_eq("rst_en", imem_en, 0);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_fcnt", fetch_cnt, 0);
    check_eq("rst_ccnt", cycle_cnt, 0);

    // Streaming: first issue in cycle 0, first output in cycle 2, one per cycle
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("str_en_c0", imem_en, 1);
    check_eq("str_addr_c0", imem_addr, 0);
    check_eq("str_valid_c0", out_valid, 0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      #1;
      if (c == 1) check_eq("str_valid_c1", out_valid, 0);
      if (c >= 2 && c <= 11) begin
        check_eq("str_valid", out_valid, 1);
        check_eq("str_pc", out_pc, 64'(4 * (c - 2)));
        check_eq("str_instr", out_instr, 64'(c - 2));
      end
      if (c == 12) begin
        check_eq("str_fcnt", fetch_cnt, 10);
        check_eq("str_ccnt", cycle_cnt, 12);
      end
    end

    // Stall: out_ready low in cycles 3..8
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      out_ready = !(c >= 3 && c <= 8);
      #1;
      check_eq("stl_en", imem_en, 64'(stall_en[c]));
      if (c >= 2) begin
        check_eq("stl_valid", out_valid, 1);
        check_eq("stl_pc", out_pc, 64'(stall_pc[c]));
        check_eq("stl_instr", out_instr, 64'(stall_pc[c] >> 2));
      end
      if (c == 12) check_eq("stl_fcnt", fetch_cnt, 4);
      @(negedge clock);
    end

    // Relative redirect in cycle 13: 0x40 + (-16) = 0x30
    redirect_valid = 1'b1;
    redirect_mode  = 1'b0;
    redirect_base  = 32'h40;
    redirect_imm   = 12'hFF0;
    #1;
    check_eq("rel_noissue", imem_en, 0);
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    check_eq("rel_en", imem_en, 1);
    check_eq("rel_addr", imem_addr, 32'h30);
    check_eq("rel_valid_r1", out_valid, 0);
    @(negedge clock);
    #1;
    check_eq("rel_valid_r2", out_valid, 0);
    @(negedge clock);
    #1;
    check_eq("rel_valid_r3", out_valid, 1);
    check_eq("rel_pc", out_pc, 32'h30);
    check_eq("rel_instr", out_instr, 32'hC);
    check_eq("rel_fcnt", fetch_cnt, 6);
    @(negedge clock);

    // Absolute redirect to 0x103 with a pop of pc 0x34 in the same cycle
    redirect_valid  = 1'b1;
    redirect_mode   = 1'b1;
    redirect_target = 32'h103;
    #1;
    check_eq("abs_pop_pc", out_pc, 32'h34);
    check_eq("abs_pop_valid", out_valid, 1);
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    check_eq("abs_addr", imem_addr, 32'h100);
    check_eq("abs_fcnt", fetch_cnt, 8);
    @(negedge clock);
    #1;
    check_eq("abs_valid_r2", out_valid, 0);
    @(negedge clock);
    #1;
    check_eq("abs_pc", out_pc, 32'h100);
    check_eq("abs_instr", out_instr, 32'h40);
    @(negedge clock);

    // Back-to-back redirects: absolute 0x200, then relative 0x80 + 8 wins
    redirect_valid  = 1'b1;
    redirect_mode   = 1'b1;
    redirect_target = 32'h200;
    @(negedge clock);
    redirect_mode = 1'b0;
    redirect_base = 32'h80;
    redirect_imm  = 12'h008;
    #1;
    check_eq("b2b_valid", out_valid, 0);
    check_eq("b2b_en", imem_en, 0);
    @(negedge clock);
    redirect_valid = 1'b0;
    #1;
    check_eq("b2b_addr", imem_addr, 32'h88);
    @(negedge clock);
    #1;
    check_eq("b2b_valid_r2", out_valid, 0);
    @(negedge clock);
    #1;
    check_eq("b2b_pc", out_pc, 32'h88);
    check_eq("b2b_instr", out_instr, 32'h22);
    check_eq("b2b_fcnt", fetch_cnt, 10);

    // Asynchronous reset between edges while streaming
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_eq("mrst_valid", out_valid, 0);
    check_eq("mrst_fcnt", fetch_cnt, 0);
    check_eq("mrst_ccnt", cycle_cnt, 0);
    check_eq("mrst_en", imem_en, 0);
    check_eq("mrst_addr", imem_addr, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("mrst_en_c0", imem_en, 1);
    check_eq("mrst_addr_c0", imem_addr, 0);
    @(negedge clock);
    #1;
    check_eq("mrst_valid_c1", out_valid, 0);
    @(negedge clock);
    #1;
    check_eq("mrst_valid_c2", out_valid, 1);
    check_eq("mrst_pc_c2", out_pc, 0);
    check_eq("mrst_instr_c2", out_instr, 0);

    // PC wrap on the 8-bit instance starting at 0xF8
    @(negedge clock);
    rst_w       = 1'b0;
    out_ready_w = 1'b1;
    @(negedge clock);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clock);
      #1;
      check_eq("wrap_valid", out_valid_w, 1);
      check_eq("wrap_pc", out_pc_w, 64'(wrap_pc[c - 2]));
      check_eq("wrap_instr", out_instr_w, 64'(32'h1000 + 32'(wrap_pc[c - 2])));
    end
    check_eq("wrap_fcnt", fetch_cnt_w, 3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction fetch unit: it holds the program counter and drives a synchronous-read instruction BRAM (1-cycle latency). It buffers returned instructions in a 2-entry queue and presents them to decode with a valid/ready handshake. It supports PC-relative and absolute redirects that squash in-flight and queued fetches. It also exposes wrapping cycle and accepted-instruction counters.

## Interface

Parameters:
- PC_W, 32, program counter and address width
- INSTR_W, 32, instruction width; PC step = INSTR_W/8 bytes
- IMM_W, 12, width of signed redirect offset
- CNT_W, 10, width of both counters
- RESET_PC, 0, PC value loaded on reset

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- redirect_valid  in  1  redirect request this cycle
- redirect_mode  in  1  0 = relative (redirect_base + sext(redirect_imm)), 1 = absolute (redirect_target)
- redirect_base  in  PC_W  PC of redirecting instruction
- redirect_imm  in  IMM_W  signed offset, bytes
- redirect_target  in  PC_W  absolute target
- imem_en  out  1  read strobe
- imem_addr  out  PC_W  read address
- imem_rdata  in  INSTR_W  data for the address strobed in the previous cycle
- out_valid  out  1  out_instr/out_pc valid
- out_ready  in  1  consumer accepts
- out_instr  out  INSTR_W  instruction at queue head
- out_pc  out  PC_W  address of out_instr
- fetch_cnt  out  CNT_W  accepted instructions since reset, wraps
- cycle_cnt  out  CNT_W  cycles since reset, wraps

## Operation

- **State**
  - fetch_pc: next address to issue.
  - inflight and inflight_pc: one outstanding read.
  - 2-entry queue of {instr, pc}, with count q_count.
- **Pop** = out_valid && out_ready.
- **Issue**
  - Issue when no redirect and (q_count + inflight − pop) ≤ 1.
  - On issue: imem_en = 1, imem_addr = fetch_pc, fetch_pc += INSTR_W/8, inflight = 1.
  - Otherwise imem_en = 0.
- **Response**
  - When inflight is set and not killed, {imem_rdata, inflight_pc} is pushed to the queue at the next edge.
  - The occupancy rule guarantees the queue never overflows.
- **Redirect**
  - The target is computed per mode. Target[1:0] is forced to 0.
  - Relative arithmetic: sign-extend redirect_imm to PC_W, add modulo 2^PC_W.
  - On the redirect edge:
    - fetch_pc = target
    - queue flushed (q_count = 0)
    - the current in-flight response is discarded (inflight cleared)
    - no issue that cycle
- **Redirect with same-cycle pop**
  - A pop in the redirect cycle completes: the consumer owns that instruction and fetch_cnt increments.
  - The remaining entries are flushed.
- **Wrap**
  - fetch_pc wraps at 2^PC_W without error.
  - Both counters wrap at 2^CNT_W.
- **Counters**
  - cycle_cnt increments every cycle out of reset.
  - fetch_cnt increments on every pop.

## Timing

- **Reset values**
  - fetch_pc = RESET_PC, imem_en = 0, imem_addr = RESET_PC
  - out_valid = 0, out_instr = 0, out_pc = 0
  - fetch_cnt = 0, cycle_cnt = 0, inflight = 0, queue empty
- **First fetch**
  - Cycle 0 after reset deassertion: imem_en = 1, addr = RESET_PC.
  - Cycle 1: data returns and is pushed.
  - Cycle 2: out_valid = 1, out_pc = RESET_PC.
- **Issue-to-output latency**: 2 cycles.
- **Throughput**: with out_ready held high, 1 instruction per cycle.
- **Stall**
  - out_ready = 0 holds out_valid, out_instr and out_pc stable.
  - Issue stops once queue plus in-flight reaches 2.
  - No instruction is lost or duplicated.
- **Redirect penalty**
  - Redirect in cycle R: issue to the target in R+1; target visible on out in R+3.
  - out_valid = 0 in R+1 and R+2.
- **Back-to-back redirects**: the last one wins; each flushes again.
- **Reset mid-operation**
  - Asynchronous: outputs take their reset values within the same cycle reset asserts.
  - In-flight data arriving after reset is ignored.

## Structure

- Package fetch_pkg:
  - REDIR_REL = 1'b0, REDIR_ABS = 1'b1
  - function for the PC step (INSTR_W/8)
  - function sext_imm for sign extension of the redirect offset
- Sub-module fetch_queue: 2-entry FIFO with push, pop, flush and count, parametrised by entry width (INSTR_W + PC_W).
- fetch_unit top: PC, issue/inflight logic, redirect target mux, counters.

## Test plan

- **Streaming**
  - Stimulus: reset, RESET_PC = 0, out_ready = 1, BRAM word k = k.
  - Required: out_pc 0, 4, 8, … on consecutive cycles from cycle 2; out_instr matches; fetch_cnt = 10 after 10 pops.
- **Stall**
  - Stimulus: out_ready = 0 for cycles 3–8, then 1.
  - Required: imem_en drops after occupancy reaches 2; out held at pc 4 during the stall; sequence resumes 4, 8, 12 with no gaps or repeats.
- **Relative redirect**
  - Stimulus: redirect_mode = 0, base = 0x40, imm = −16 (0xFF0).
  - Required: imem_addr = 0x30 the next cycle; the next out_pc is 0x30, with no stale pc emitted.
- **Absolute redirect with pop**
  - Stimulus: redirect_mode = 1, target = 0x103, with a pop in the same cycle.
  - Required: the popped instruction counted; next out_pc = 0x100.
- **PC wrap**
  - Stimulus: PC_W = 8, RESET_PC = 0xF8.
  - Required: out_pc 0xF8, 0xFC, 0x00, 0x04.
- **Mid-operation reset**
  - Stimulus: assert reset asynchronously mid-stream, between clock edges.
  - Required: out_valid = 0 and both counters = 0 immediately; restart fetch at RESET_PC.
